plab4_net_router_output_ctrl: RTL and testbench

Per-output-port controller of the ring router: the responder side of the `reqs`/`grants` handshake driven by the three input-port controllers (west, terminal, east). Each cycle it grants at most one requester by round-robin, gated by downstream readiness and by a credit counter tracking free slots in the neighbour's input queue. It drives the `num_free` count the input controllers use for bubble flow control. One instance per output port: west, terminal, east.

---
 rtl/plab4_net_router_output_ctrl_pkg.sv | 41 ++++
 rtl/plab4_net_credit_counter.sv | 50 +++++
 rtl/plab4_net_router_output_ctrl.sv | 107 ++++++++++
 tb/tb_plab4_net_router_output_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared router definitions: port indices and the reqs/grants bit encoding
// used by the output controller and the input-port controllers.
package plab4_net_router_output_ctrl_pkg;

    // Port index, also the crossbar select value for that port
    typedef enum logic [1:0] {
        PORT_EAST = 2'd0,
        PORT_TERM = 2'd1,
        PORT_WEST = 2'd2
    } port_idx_e;

    // One-hot request/grant bit for each port
    localparam logic [2:0] REQ_EAST = 3'b001;
    localparam logic [2:0] REQ_TERM = 3'b010;
    localparam logic [2:0] REQ_WEST = 3'b100;

    // Map a port index to its one-hot reqs/grants bit
    function automatic logic [2:0] port_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            PORT_EAST: oh = REQ_EAST;
            PORT_TERM: oh = REQ_TERM;
            PORT_WEST: oh = REQ_WEST;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin successor of a port index (mod 3)
    function automatic logic [1:0] port_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            PORT_EAST: nxt = PORT_TERM;
            PORT_TERM: nxt = PORT_WEST;
            PORT_WEST: nxt = PORT_EAST;
            default:   nxt = PORT_EAST;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/plab4_net_credit_counter.sv
// Free-slot counter for the downstream input queue. Starts full, counts down
// on each send and up on each returned credit; a return while already full
// saturates and raises a sticky error.
module plab4_net_credit_counter #(
    parameter int p_num_free_nbits = 2,
    parameter int p_max_credits    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dec,
    input  logic                        inc,
    output logic [p_num_free_nbits-1:0] count,
    output logic                        err
);

    localparam logic [p_num_free_nbits-1:0] MAX_C  = p_num_free_nbits'(p_max_credits);
    localparam logic [p_num_free_nbits-1:0] ONE_C  = p_num_free_nbits'(1);
    localparam logic [p_num_free_nbits-1:0] ZERO_C = p_num_free_nbits'(0);

    logic [p_num_free_nbits-1:0] count_r;
    logic                        err_r;

    // Credit count and sticky overflow flag; simultaneous inc/dec cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= MAX_C;
            err_r   <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (count_r == MAX_C) begin
                    err_r <= 1'b1;
                end else begin
                    count_r <= count_r + ONE_C;
                end
            end else if (dec && !inc) begin
                if (count_r != ZERO_C) begin
                    count_r <= count_r - ONE_C;
                end else begin
                    count_r <= count_r;
                end
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign count = count_r;
    assign err   = err_r;

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller of the ring router: round-robin arbiter over the
// west/terminal/east requesters, gated by downstream readiness and credits.
module plab4_net_router_output_ctrl
    import plab4_net_router_output_ctrl_pkg::*;
#(
    parameter int p_num_free_nbits = 2,
    parameter int p_max_credits    = 3,
    parameter int p_track_credits  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    output logic                        out_val,
    input  logic                        out_rdy,
    input  logic                        credit_ret,
    output logic [p_num_free_nbits-1:0] num_free,
    output logic [1:0]                  xbar_sel,
    output logic                        credit_err
);

    localparam logic TRACK_C = (p_track_credits != 0);

    logic [1:0]                  prio_r;
    logic [1:0]                  grant_idx_s;
    logic                        grant_vld_s;
    logic                        can_send_s;
    logic [2:0]                  grants_s;
    logic [1:0]                  xbar_sel_s;
    logic                        out_val_s;
    logic [p_num_free_nbits-1:0] num_free_s;
    logic                        credit_err_s;

    // Send permission: downstream ready and a free slot (if credits are tracked)
    always_comb begin
        can_send_s = out_rdy && ((num_free_s != '0) || !TRACK_C);
    end

    // Round-robin scan from prio_r, then gate by reset, permission and requests
    always_comb begin
        grant_idx_s = PORT_EAST;
        case (prio_r)
            PORT_EAST: begin
                if (reqs[0])      grant_idx_s = PORT_EAST;
                else if (reqs[1]) grant_idx_s = PORT_TERM;
                else              grant_idx_s = PORT_WEST;
            end
            PORT_TERM: begin
                if (reqs[1])      grant_idx_s = PORT_TERM;
                else if (reqs[2]) grant_idx_s = PORT_WEST;
                else              grant_idx_s = PORT_EAST;
            end
            PORT_WEST: begin
                if (reqs[2])      grant_idx_s = PORT_WEST;
                else if (reqs[0]) grant_idx_s = PORT_EAST;
                else              grant_idx_s = PORT_TERM;
            end
            default: begin
                if (reqs[0])      grant_idx_s = PORT_EAST;
                else if (reqs[1]) grant_idx_s = PORT_TERM;
                else              grant_idx_s = PORT_WEST;
            end
        endcase

        grant_vld_s = reset && can_send_s && (reqs != 3'b000);

        if (grant_vld_s) begin
            grants_s   = port_onehot(grant_idx_s);
            xbar_sel_s = grant_idx_s;
        end else begin
            grants_s   = 3'b000;
            xbar_sel_s = 2'd0;
        end
        out_val_s = grant_vld_s;
    end

    // Priority pointer moves just past the port granted on a transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= PORT_EAST;
        end else if (out_val_s) begin
            prio_r <= port_next(grant_idx_s);
        end else begin
            prio_r <= prio_r;
        end
    end

    // Credit loop; with tracking disabled the counter never moves off full
    plab4_net_credit_counter #(
        .p_num_free_nbits (p_num_free_nbits),
        .p_max_credits    (p_max_credits)
    ) u_credit_counter (
        .clk   (clk),
        .reset (reset),
        .dec   (out_val_s && TRACK_C),
        .inc   (credit_ret && TRACK_C),
        .count (num_free_s),
        .err   (credit_err_s)
    );

    assign grants     = grants_s;
    assign out_val    = out_val_s;
    assign xbar_sel   = xbar_sel_s;
    assign num_free   = num_free_s;
    assign credit_err = credit_err_s;

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Scoreboard bench for the router output controller: the driver pushes the
// hand-computed expected outputs per cycle, a monitor pops and compares them.
module tb_plab4_net_router_output_ctrl;

    logic       clk;
    logic       reset;

    // Instance A: credit-tracked ring output
    logic [2:0] reqs_a;
    logic [2:0] grants_a;
    logic       out_val_a;
    logic       out_rdy_a;
    logic       credit_ret_a;
    logic [1:0] num_free_a;
    logic [1:0] xbar_sel_a;
    logic       credit_err_a;

    // Instance B: terminal output, no credit loop
    logic [2:0] reqs_b;
    logic [2:0] grants_b;
    logic       out_val_b;
    logic       out_rdy_b;
    logic       credit_ret_b;
    logic [1:0] num_free_b;
    logic [1:0] xbar_sel_b;
    logic       credit_err_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [2:0] g;
        logic [1:0] nf;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    plab4_net_router_output_ctrl #(
        .p_num_free_nbits (2),
        .p_max_credits    (3),
        .p_track_credits  (1)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .reqs       (reqs_a),
        .grants     (grants_a),
        .out_val    (out_val_a),
        .out_rdy    (out_rdy_a),
        .credit_ret (credit_ret_a),
        .num_free   (num_free_a),
        .xbar_sel   (xbar_sel_a),
        .credit_err (credit_err_a)
    );

    plab4_net_router_output_ctrl #(
        .p_num_free_nbits (2),
        .p_max_credits    (3),
        .p_track_credits  (0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .reqs       (reqs_b),
        .grants     (grants_b),
        .out_val    (out_val_b),
        .out_rdy    (out_rdy_b),
        .credit_ret (credit_ret_b),
        .num_free   (num_free_b),
        .xbar_sel   (xbar_sel_b),
        .credit_err (credit_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] xbar_of(input logic [2:0] g);
        case (g)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // One cycle of stimulus for instance id, with its expected outputs
    task automatic step(input int id, input logic [2:0] rq, input logic rdy, input logic cr,
                        input logic rst, input logic [2:0] eg, input logic [1:0] enf,
                        input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        if (id == 0) begin
            reqs_a = rq; out_rdy_a = rdy; credit_ret_a = cr;
            reqs_b = 3'b000; out_rdy_b = 1'b0; credit_ret_b = 1'b0;
        end else begin
            reqs_b = rq; out_rdy_b = rdy; credit_ret_b = cr;
            reqs_a = 3'b000; out_rdy_a = 1'b0; credit_ret_a = 1'b0;
        end
        e.id = id; e.g = eg; e.nf = enf; e.err = eerr;
        exp_q.push_back(e);
    endtask

    // Async reset dropped mid-cycle while a grant is active on instance A
    task automatic mid_cycle_reset();
        exp_t e;
        @(posedge clk);
        #1;
        reqs_a = 3'b111; out_rdy_a = 1'b1; credit_ret_a = 1'b0;
        #1;
        reset = 1'b0;
        e.id = 0; e.g = 3'b000; e.nf = 2'd3; e.err = 1'b0;
        exp_q.push_back(e);
        #5;
        reqs_a = 3'b000;
        reset  = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.id == 0) begin
                    chk("a_grants",   {5'd0, grants_a},     {5'd0, e.g});
                    chk("a_out_val",  {7'd0, out_val_a},    {7'd0, (e.g != 3'b000)});
                    chk("a_xbar_sel", {6'd0, xbar_sel_a},   {6'd0, xbar_of(e.g)});
                    chk("a_num_free", {6'd0, num_free_a},   {6'd0, e.nf});
                    chk("a_cred_err", {7'd0, credit_err_a}, {7'd0, e.err});
                end else begin
                    chk("b_grants",   {5'd0, grants_b},     {5'd0, e.g});
                    chk("b_out_val",  {7'd0, out_val_b},    {7'd0, (e.g != 3'b000)});
                    chk("b_xbar_sel", {6'd0, xbar_sel_b},   {6'd0, xbar_of(e.g)});
                    chk("b_num_free", {6'd0, num_free_b},   {6'd0, e.nf});
                    chk("b_cred_err", {7'd0, credit_err_b}, {7'd0, e.err});
                end
            end
        end
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        reqs_a = 3'b000; out_rdy_a = 1'b0; credit_ret_a = 1'b0;
        reqs_b = 3'b000; out_rdy_b = 1'b0; credit_ret_b = 1'b0;

        // Held in reset: requests are ignored
        step(0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0);

        // Release with all requesting: round-robin until credits run out
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 2'd3, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 2'd2, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 2'd1, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);

        // No credits: blocked; a returned credit is usable next cycle
        step(0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);
        step(0, 3'b010, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0);
        step(0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 2'd1, 1'b0);
        step(0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0);

        // Build to 2 credits, then transfer and return in the same cycle
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0);
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0);
        step(0, 3'b111, 1'b1, 1'b1, 1'b1, 3'b100, 2'd2, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 2'd2, 1'b0);

        // Refill, then over-return: saturates and sets the sticky error
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0);
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd2, 1'b0);
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd3, 1'b0);
        step(0, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);

        // Move prio back to east, then stall on out_rdy = 0
        step(0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 2'd3, 1'b1);
        step(0, 3'b100, 1'b1, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'b101, 1'b0, 1'b0, 1'b1, 3'b000, 2'd1, 1'b1);
        end
        step(0, 3'b101, 1'b1, 1'b0, 1'b1, 3'b001, 2'd1, 1'b1);

        // One credit back, then async reset while a grant is showing
        step(0, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd0, 1'b1);
        mid_cycle_reset();
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 2'd3, 1'b0);
        step(0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 2'd2, 1'b0);
        step(0, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 2'd1, 1'b0);

        // Untracked output: 10 sends, credit returns ignored, count stays full
        step(1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b001, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b100, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b010, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b100, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b001, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b1, 1'b1, 3'b100, 2'd3, 1'b0);
        step(1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 2'd3, 1'b0);
        step(1, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 2'd3, 1'b0);

        // Drain: every expectation must have been consumed
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
